booth_mult_seq: RTL

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier for signed (mult) and unsigned (multu) operands.
// Operands are extended to WIDTH+1 bits so one datapath serves both modes.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               workMult,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   oper_A,
  input  logic [WIDTH-1:0]   oper_B,
  output logic [2*WIDTH-1:0] mul,
  output logic               endMult,
  output logic               busy
);
  localparam int XW = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      acc_q, acc_d;
  logic [XW-1:0]      q_reg_q, q_reg_d;
  logic [XW-1:0]      m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mul_q, mul_d;
  logic               end_q, end_d;
  logic               busy_q, busy_d;
  logic [XW-1:0]      sum;
  logic [2*XW-1:0]    shifted;

  always_comb begin
    sum = acc_q;
    case ({q_reg_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  // Arithmetic right shift of {acc, Q}; the bit leaving Q becomes the new q_-1.
  assign shifted = {sum[XW-1], sum, q_reg_q[XW-1:1]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_reg_d = q_reg_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    end_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (workMult) begin
          acc_d   = '0;
          q_reg_d = {is_signed & oper_B[WIDTH-1], oper_B};
          m_d     = {is_signed & oper_A[WIDTH-1], oper_A};
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = shifted[2*XW-1:XW];
        q_reg_d = shifted[XW-1:0];
        qm1_d   = q_reg_q[0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          mul_d   = shifted[2*WIDTH-1:0];
          end_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_reg_q <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      mul_q   <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_reg_q <= q_reg_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign mul     = mul_q;
  assign endMult = end_q;
  assign busy    = busy_q;
endmodule
